// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the two M-stage lanes, serving lane 0 before lane 1,
// sequencing each multi-cycle access and holding both M-stage stalls until the bundle is done.
module dmem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          stallm,
    output logic          stallm2,
    output logic          busy
);

    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          we_q;
    logic [1:0]    served;

    logic          pend0;
    logic          pend1;
    logic          sel_valid;
    logic          sel_lane;
    logic          req_own;
    logic          load_done;
    logic          done;

    assign pend0     = req0 & ~served[0];
    assign pend1     = req1 & ~served[1];
    assign stallm    = pend0 | pend1;
    assign stallm2   = stallm;
    assign busy      = (state != IDLE);

    // Lane 0 is the older instruction, so it always takes the port first.
    assign sel_valid = (state == IDLE) & (pend0 | pend1);
    assign sel_lane  = ~pend0;
    assign req_own   = owner ? req1 : req0;
    assign load_done = (state == WAIT) && (cnt == '0);
    assign done      = ((state == ISSUE) && we_q) || load_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend0 | pend1) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? IDLE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // The memory command is launched straight from registers, so mem_en is high exactly in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            mem_en <= sel_valid;
            mem_we <= sel_valid & (sel_lane ? we1 : we0);
            if (sel_valid) begin
                owner     <= sel_lane;
                we_q      <= sel_lane ? we1 : we0;
                mem_addr  <= sel_lane ? addr1 : addr0;
                mem_wdata <= sel_lane ? wdata1 : wdata0;
            end
        end
    end

    // A flushed owner (req dropped mid-access) still finishes the access but is not marked served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served <= 2'b00;
        end else if (!stallm) begin
            served <= 2'b00;
        end else if (done && req_own) begin
            served[owner] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (load_done && req_own) begin
            if (owner) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata0 <= mem_rdata;
            end
        end
    end

    a_we_qualified: assert property (@(posedge clk) disable iff (rst) mem_we |-> mem_en);
    a_en_single:    assert property (@(posedge clk) disable iff (rst) mem_en |=> !mem_en);

endmodule
